// File: rtl/noc_rr_arbiter_if.sv
// rtl/noc_rr_arbiter_if.sv - handshake bundle between an output-port arbiter and its channels
//
// Purpose: groups the request, crossbar-select and RTS/DCTS flit handshake signals of
//          noc_rr_arbiter. The arbiter side uses modport master, the channel/downstream
//          side uses modport slave.
// Optional feature macro: ARB_GRANT_CNT_EN adds the per-port grant counter bus.
// Signals:
//   req       NUM_PORTS        per-channel request, level
//   dcts      1                downstream clear-to-send
//   grant     NUM_PORTS        one-hot transfer strobe to the winning input
//   xbar_sel  NUM_PORTS        one-hot crossbar select of the current owner, 0 when idle
//   rts       1                registered request-to-send downstream
//   grant_cnt NUM_PORTS*CNT_W  per-port grant counters (ARB_GRANT_CNT_EN only)

interface noc_rr_arbiter_if #(
    parameter int NUM_PORTS = 5,
    parameter int CNT_W     = 16
);
    logic [NUM_PORTS-1:0] req;
    logic                 dcts;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] xbar_sel;
    logic                 rts;

    // Parameter sanity checks, evaluated at elaboration.
    if (NUM_PORTS < 2) begin : g_bad_num_ports
        $error("noc_rr_arbiter_if: NUM_PORTS must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("noc_rr_arbiter_if: CNT_W must be >= 1");
    end

`ifdef ARB_GRANT_CNT_EN
    logic [NUM_PORTS*CNT_W-1:0] grant_cnt;

    modport master (
        input  req,
        input  dcts,
        output grant,
        output xbar_sel,
        output rts,
        output grant_cnt
    );

    modport slave (
        output req,
        output dcts,
        input  grant,
        input  xbar_sel,
        input  rts,
        input  grant_cnt
    );
`else
    modport master (
        input  req,
        input  dcts,
        output grant,
        output xbar_sel,
        output rts
    );

    modport slave (
        output req,
        output dcts,
        input  grant,
        input  xbar_sel,
        input  rts
    );
`endif

endinterface

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - sticky round-robin output-port arbiter with burst limit and RTS/DCTS handshake
//
// Purpose: picks one of NUM_PORTS input channels with sticky round-robin priority, forces
//          rotation after MAX_BURST consecutive transfers (0 = unlimited), drives a one-hot
//          crossbar select and runs the one-flit-per-two-cycles RTS/DCTS handshake downstream.
// Optional feature macro: ARB_GRANT_CNT_EN adds saturating per-port grant counters.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   noc_rr_arbiter_if.master: req/dcts in; grant/xbar_sel/rts (and grant_cnt) out

module noc_rr_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_rr_arbiter_if.master       bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int BC_W  = ($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("noc_rr_arbiter: CNT_W must be >= 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e               state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     last;
    logic [BC_W-1:0]      burst_cnt;
    logic                 rts_q;

    logic                 busy;
    logic                 xfer;
    logic                 stall;
    logic [NUM_PORTS-1:0] owner_onehot;

    logic [IDX_W-1:0]     search_base;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic                 burst_ok;
    logic                 keep;

    logic                 next_busy;
    logic [IDX_W-1:0]     next_owner;
    logic [BC_W-1:0]      next_cnt;

    assign busy         = (state == ST_OWN);
    // Transfers are suppressed while rst is high so a reset mid-transfer yields no grant.
    assign xfer         = busy & rts_q & bus.dcts & ~rst;
    assign stall        = rts_q & ~bus.dcts;
    assign owner_onehot = NUM_PORTS'(1) << owner;

    assign bus.grant    = xfer ? owner_onehot : '0;
    assign bus.xbar_sel = busy ? owner_onehot : '0;
    assign bus.rts      = rts_q;

    // Round-robin search: starting just after the base, wrapping, so the base itself is
    // considered last. Idle searches from the last-served port, an owner from itself.
    always_comb begin
        search_base = busy ? owner : last;
        found       = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(search_base) + k) % NUM_PORTS);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // The pending transfer counts toward the burst so the limit is hit on the
    // MAX_BURST-th transfer itself rather than one cycle later.
    always_comb begin
        burst_ok = (MAX_BURST == 0) || ((int'(burst_cnt) + int'(xfer)) < MAX_BURST);
        keep     = busy & bus.req[owner] & burst_ok;
    end

    always_comb begin
        next_busy  = 1'b0;
        next_owner = owner;
        next_cnt   = '0;
        if (keep) begin
            next_busy  = 1'b1;
            next_cnt   = burst_cnt + BC_W'(xfer);
        end else if (found) begin
            // Covers both a change of owner and rotation re-selecting the same owner;
            // either way a fresh burst starts.
            next_busy  = 1'b1;
            next_owner = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            last      <= IDX_W'(NUM_PORTS - 1);
            burst_cnt <= '0;
            rts_q     <= 1'b0;
        end else if (!stall) begin
            state     <= next_busy ? ST_OWN : ST_IDLE;
            owner     <= next_owner;
            burst_cnt <= next_cnt;
            // RTS drops for one cycle after each flit, giving one flit per two cycles.
            rts_q     <= next_busy & ~xfer;
            if (xfer) begin
                last <= owner;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0]           gcnt [NUM_PORTS];
    logic [NUM_PORTS*CNT_W-1:0] gcnt_flat;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_gcnt
        always_ff @(posedge clk) begin
            if (rst) begin
                gcnt[i] <= '0;
            end else if (bus.grant[i] && (gcnt[i] != {CNT_W{1'b1}})) begin
                gcnt[i] <= gcnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        gcnt_flat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gcnt_flat[i*CNT_W +: CNT_W] = gcnt[i];
        end
    end

    assign bus.grant_cnt = gcnt_flat;
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb/tb_noc_rr_arbiter.sv - self-checking bench for noc_rr_arbiter with a behavioural reference model

module tb_noc_rr_arbiter;

    localparam int N    = 5;
    localparam int MB   = 4;
    localparam int CW   = 8;
    localparam int GMAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    noc_rr_arbiter_if #(.NUM_PORTS(N), .CNT_W(CW)) bus ();

    noc_rr_arbiter #(
        .NUM_PORTS (N),
        .MAX_BURST (MB),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner as an integer (-1 style idle via m_busy), plain counters.
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_last;
    bit m_rts;
    int m_gcnt [N];

    logic [N-1:0] obs_grant, obs_xbar, exp_grant, exp_xbar;
    logic         obs_rts, exp_rts;
`ifdef ARB_GRANT_CNT_EN
    logic [N*CW-1:0] obs_gcnt, exp_gcnt;
`endif

    function automatic logic [N-1:0] port_bit(input int p);
        logic [N-1:0] one;
        one = 1;
        return one << p;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = N - 1;
        m_rts   = 0;
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    endtask

    // Advances the model by one clock using the inputs held during that cycle.
    task automatic model_step();
        bit xf;
        bit nb;
        int base, win, no, nc;
        if (rst) begin
            model_reset();
            return;
        end
        xf = m_busy && m_rts && bus.dcts;
        if (xf && m_gcnt[m_owner] < GMAX) m_gcnt[m_owner]++;
        if (m_rts && !bus.dcts) return;
        if (m_busy && bus.req[m_owner] && (MB == 0 || (m_cnt + int'(xf)) < MB)) begin
            nb = 1;
            no = m_owner;
            nc = m_cnt + int'(xf);
        end else begin
            base = m_busy ? m_owner : m_last;
            win  = -1;
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && bus.req[(base + k) % N]) win = (base + k) % N;
            end
            nb = (win >= 0);
            no = nb ? win : m_owner;
            nc = 0;
        end
        if (xf) m_last = m_owner;
        m_rts   = nb && !xf;
        m_busy  = nb;
        m_owner = no;
        m_cnt   = nc;
    endtask

    // Entered and left at posedge+1; samples outputs at the falling edge.
    task automatic cycle();
        bit xf;
        @(negedge clk);
        obs_grant = bus.grant;
        obs_xbar  = bus.xbar_sel;
        obs_rts   = bus.rts;
        xf        = !rst && m_busy && m_rts && bus.dcts;
        exp_grant = xf ? port_bit(m_owner) : '0;
        exp_xbar  = m_busy ? port_bit(m_owner) : '0;
        exp_rts   = m_rts;
`ifdef ARB_GRANT_CNT_EN
        obs_gcnt  = bus.grant_cnt;
        for (int i = 0; i < N; i++) exp_gcnt[i*CW +: CW] = CW'(m_gcnt[i]);
`endif
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus.dcts = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.req  = 5'b11111;
        bus.dcts = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        n_cmp++; if (obs_grant !== 5'b0) begin n_bad++; $display("FAIL reset_grant: got %b want %b", obs_grant, 5'b0); end
        n_cmp++; if (obs_xbar !== 5'b0) begin n_bad++; $display("FAIL reset_xbar: got %b want %b", obs_xbar, 5'b0); end
        n_cmp++; if (obs_rts !== 1'b0) begin n_bad++; $display("FAIL reset_rts: got %b want %b", obs_rts, 1'b0); end
        rst     = 1'b0;
        bus.req = 5'b00110;
        cycle();
        n_cmp++; if (obs_xbar !== 5'b0) begin n_bad++; $display("FAIL first_idle_xbar: got %b want %b", obs_xbar, 5'b0); end
        cycle();
        n_cmp++; if (obs_xbar !== 5'b00010) begin n_bad++; $display("FAIL first_xbar: got %b want %b", obs_xbar, 5'b00010); end
        n_cmp++; if (obs_rts !== 1'b1) begin n_bad++; $display("FAIL first_rts: got %b want %b", obs_rts, 1'b1); end
    endtask

    task automatic test_toggle();
        do_reset();
        bus.req  = 5'b01000;
        bus.dcts = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i >= 1) begin
                n_cmp++; if (obs_rts !== ((i % 2) == 1)) begin n_bad++; $display("FAIL toggle_rts[%0d]: got %b want %b", i, obs_rts, (i % 2) == 1); end
                n_cmp++; if (obs_grant !== (((i % 2) == 1) ? 5'b01000 : 5'b0)) begin n_bad++; $display("FAIL toggle_grant[%0d]: got %b", i, obs_grant); end
                n_cmp++; if (obs_xbar !== 5'b01000) begin n_bad++; $display("FAIL toggle_xbar[%0d]: got %b want %b", i, obs_xbar, 5'b01000); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.req  = 5'b00100;
        bus.dcts = 1'b0;
        cycle();
        cycle();
        bus.req = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++; if (obs_xbar !== 5'b00100) begin n_bad++; $display("FAIL stall_xbar[%0d]: got %b want %b", i, obs_xbar, 5'b00100); end
            n_cmp++; if (obs_rts !== 1'b1) begin n_bad++; $display("FAIL stall_rts[%0d]: got %b want %b", i, obs_rts, 1'b1); end
            n_cmp++; if (obs_grant !== 5'b0) begin n_bad++; $display("FAIL stall_grant[%0d]: got %b want %b", i, obs_grant, 5'b0); end
        end
        bus.dcts = 1'b1;
        cycle();
        n_cmp++; if (obs_grant !== 5'b00100) begin n_bad++; $display("FAIL stall_release_grant: got %b want %b", obs_grant, 5'b00100); end
        cycle();
        n_cmp++; if (obs_xbar !== 5'b10000) begin n_bad++; $display("FAIL stall_next_owner: got %b want %b", obs_xbar, 5'b10000); end
    endtask

    task automatic test_burst_rotation();
        int run_port, run_len, runs, p;
        do_reset();
        bus.req  = 5'b00011;
        bus.dcts = 1'b1;
        run_port = -1;
        run_len  = 0;
        runs     = 0;
        for (int c = 0; c < 48; c++) begin
            cycle();
            n_cmp++; if (obs_grant !== exp_grant) begin n_bad++; $display("FAIL burst_grant[%0d]: got %b want %b", c, obs_grant, exp_grant); end
            if (obs_grant != '0) begin
                p = -1;
                for (int b = 0; b < N; b++) if (obs_grant[b]) p = b;
                if (p == run_port) begin
                    run_len++;
                end else begin
                    if (run_port >= 0) begin
                        n_cmp++; if (run_len != MB) begin n_bad++; $display("FAIL burst_len port%0d: got %0d want %0d", run_port, run_len, MB); end
                    end
                    n_cmp++; if (p != (runs % 2)) begin n_bad++; $display("FAIL burst_order run%0d: got port%0d want port%0d", runs, p, runs % 2); end
                    runs++;
                    run_port = p;
                    run_len  = 1;
                end
            end
        end
        n_cmp++; if (runs < 4) begin n_bad++; $display("FAIL burst_runs: got %0d want >= 4", runs); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        bus.req  = 5'b10000;
        bus.dcts = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (obs_xbar !== 5'b10000) begin n_bad++; $display("FAIL wrap_setup_xbar: got %b want %b", obs_xbar, 5'b10000); end
        bus.req  = 5'b01001;
        bus.dcts = 1'b1;
        cycle();
        n_cmp++; if (obs_grant !== 5'b10000) begin n_bad++; $display("FAIL wrap_grant: got %b want %b", obs_grant, 5'b10000); end
        cycle();
        n_cmp++; if (obs_xbar !== 5'b00001) begin n_bad++; $display("FAIL wrap_owner: got %b want %b", obs_xbar, 5'b00001); end
        bus.req = 5'b00001;
        for (int k = 0; k < 4 && !m_rts; k++) cycle();
        n_cmp++; if (!m_rts) begin n_bad++; $display("FAIL midburst_setup: got rts %b want %b", m_rts, 1'b1); end
        rst = 1'b1;
        cycle();
        n_cmp++; if (obs_rts !== 1'b1) begin n_bad++; $display("FAIL midburst_rts_before: got %b want %b", obs_rts, 1'b1); end
        n_cmp++; if (obs_grant !== 5'b0) begin n_bad++; $display("FAIL midburst_abort_grant: got %b want %b", obs_grant, 5'b0); end
        rst = 1'b0;
        cycle();
        n_cmp++; if (obs_rts !== 1'b0) begin n_bad++; $display("FAIL midburst_rts_after: got %b want %b", obs_rts, 1'b0); end
        n_cmp++; if (obs_xbar !== 5'b0) begin n_bad++; $display("FAIL midburst_xbar_after: got %b want %b", obs_xbar, 5'b0); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, (1 << N) - 1));
            bus.dcts = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 199) == 0);
            cycle();
            n_cmp++; if (obs_grant !== exp_grant) begin n_bad++; $display("FAIL rand_grant[%0d]: got %b want %b", c, obs_grant, exp_grant); end
            n_cmp++; if (obs_xbar !== exp_xbar) begin n_bad++; $display("FAIL rand_xbar[%0d]: got %b want %b", c, obs_xbar, exp_xbar); end
            n_cmp++; if (obs_rts !== exp_rts) begin n_bad++; $display("FAIL rand_rts[%0d]: got %b want %b", c, obs_rts, exp_rts); end
            n_cmp++; if (obs_rts === 1'b1 && obs_xbar === 5'b0) begin n_bad++; $display("FAIL rand_rts_idle[%0d]: got rts %b xbar %b", c, obs_rts, obs_xbar); end
`ifdef ARB_GRANT_CNT_EN
            n_cmp++; if (obs_gcnt !== exp_gcnt) begin n_bad++; $display("FAIL rand_gcnt[%0d]: got %h want %h", c, obs_gcnt, exp_gcnt); end
`endif
        end
        rst = 1'b0;
    endtask

`ifdef ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        do_reset();
        bus.req  = 5'b00010;
        bus.dcts = 1'b1;
        repeat (620) cycle();
        cycle();
        n_cmp++; if (obs_gcnt[15:8] !== 8'd255) begin n_bad++; $display("FAIL gcnt_sat: got %0d want %0d", obs_gcnt[15:8], 255); end
        n_cmp++; if ({obs_gcnt[39:16], obs_gcnt[7:0]} !== 32'd0) begin n_bad++; $display("FAIL gcnt_others: got %h want 0", {obs_gcnt[39:16], obs_gcnt[7:0]}); end
        n_cmp++; if (obs_gcnt !== exp_gcnt) begin n_bad++; $display("FAIL gcnt_model: got %h want %h", obs_gcnt, exp_gcnt); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.dcts = 1'b0;
        model_reset();
        test_reset();
        test_toggle();
        test_stall();
        test_burst_rotation();
        test_wrap_and_reset();
        test_random();
`ifdef ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
